// File: rtl/lpm_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
// The slave side is the arbiter; the master side drives requests and release.
interface lpm_rr_arbiter_if #(
    parameter int WIDTH    = 2,
    parameter int REQUESTS = 1 << WIDTH
);
    logic                clken;
    logic [REQUESTS-1:0] i_req;
    logic                i_done;
    logic [REQUESTS-1:0] o_gnt;
    logic [WIDTH-1:0]    o_gnt_idx;
    logic                o_gnt_valid;
    logic                o_timeout;

    modport master (
        output clken, i_req, i_done,
        input  o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
    );

    modport slave (
        input  clken, i_req, i_done,
        output o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
    );
endinterface

// File: rtl/lpm_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index and an
// optional hold limit that forces the current holder to release.
module lpm_rr_arbiter #(
    parameter string lpm_type     = "lpm_rr_arbiter",
    parameter int    lpm_width    = 2,
    parameter int    lpm_requests = 1 << lpm_width,
    parameter int    lpm_hold_max = 0,
    parameter string lpm_hint     = "UNUSED"
) (
    input logic              i_clock,
    input logic              i_sclr,
    lpm_rr_arbiter_if.slave  bus
);
    localparam int CW = (lpm_hold_max > 0) ? $clog2(lpm_hold_max + 1) : 1;
    localparam logic [CW-1:0]        CNT_LAST = (lpm_hold_max > 0) ? CW'(lpm_hold_max - 1) : '0;
    localparam logic [lpm_width-1:0] IDX_LAST = lpm_width'(lpm_requests - 1);

    if (lpm_requests < 2 || lpm_requests > (1 << lpm_width)) begin : g_bad_cfg
        $error("%s (%s): lpm_requests out of range", lpm_type, lpm_hint);
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  r_state,     w_state_nxt;
    logic [lpm_requests-1:0] r_gnt,       w_gnt_nxt;
    logic [lpm_width-1:0]    r_gnt_idx,   w_gnt_idx_nxt;
    logic                    r_gnt_valid, w_gnt_valid_nxt;
    logic                    r_timeout,   w_timeout_nxt;
    logic [lpm_width-1:0]    r_ptr,       w_ptr_nxt;
    logic [CW-1:0]           r_cnt,       w_cnt_nxt;

    logic                 w_found;
    logic [lpm_width-1:0] w_sel;
    logic                 w_natural, w_forced, w_release;

    // Rotating search: first set request at or after the priority pointer.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < lpm_requests; i++) begin
            j = int'(r_ptr) + i;
            if (j >= lpm_requests) j = j - lpm_requests;
            if (!w_found && bus.i_req[j]) begin
                w_found = 1'b1;
                w_sel   = j[lpm_width-1:0];
            end
        end
    end

    assign w_natural = bus.i_done | ~bus.i_req[r_gnt_idx];
    assign w_forced  = (lpm_hold_max != 0) && (r_cnt == CNT_LAST);
    assign w_release = w_natural | w_forced;

    always_ff @(posedge i_clock) begin
        if (i_sclr) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
        end else if (bus.clken) begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt        = GRANT;
                    w_gnt_nxt          = '0;
                    w_gnt_nxt[w_sel]   = 1'b1;
                    w_gnt_idx_nxt      = w_sel;
                    w_gnt_valid_nxt    = 1'b1;
                    w_cnt_nxt          = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // Index stays on the last holder so it remains observable in the bubble.
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_timeout_nxt   = w_forced & ~w_natural;
                    w_ptr_nxt       = (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_idx   = r_gnt_idx;
    assign bus.o_gnt_valid = r_gnt_valid;
    assign bus.o_timeout   = r_timeout;
endmodule

// File: tb/tb_lpm_rr_arbiter.sv
// Scoreboarded bench: stimulus steps an abstract arbiter model and queues the
// expected outputs; a monitor compares them one cycle later against the DUT.
module tb_lpm_rr_arbiter;
    localparam int W = 2;
    localparam int N = 4;
    localparam int H = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] idx;
        logic         vld;
        logic         tmo;
    } exp_t;

    logic clk  = 1'b0;
    logic sclr = 1'b1;
    always #5 clk = ~clk;

    lpm_rr_arbiter_if #(.WIDTH(W), .REQUESTS(N)) ifc ();

    lpm_rr_arbiter #(
        .lpm_type("lpm_rr_arbiter"), .lpm_width(W), .lpm_requests(N),
        .lpm_hold_max(H), .lpm_hint("UNUSED")
    ) dut (
        .i_clock(clk),
        .i_sclr (sclr),
        .bus    (ifc.slave)
    );

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Abstract model: who holds the grant, for how many visible cycles, and who is next in line.
    int holder   = -1;
    int ptr      = 0;
    int age      = 0;
    int last_idx = 0;
    bit tmo      = 0;

    task automatic model_step(input bit s, input bit en, input logic [N-1:0] rq, input bit dn);
        exp_t e;
        if (s) begin
            holder = -1; ptr = 0; age = 0; last_idx = 0; tmo = 0;
        end else if (en) begin
            if (holder < 0) begin
                tmo = 0;
                for (int i = 0; i < N; i++) begin
                    if (holder < 0 && rq[(ptr + i) % N]) begin
                        holder   = (ptr + i) % N;
                        last_idx = holder;
                        age      = 1;
                    end
                end
            end else begin
                bit nat, frc;
                nat = dn || !rq[holder];
                frc = (H != 0) && (age == H);
                if (nat || frc) begin
                    tmo    = frc && !nat;
                    ptr    = (holder + 1) % N;
                    holder = -1;
                end else begin
                    age++;
                    tmo = 0;
                end
            end
        end
        e.gnt = (holder >= 0) ? N'(1) << holder : '0;
        e.idx = W'(last_idx);
        e.vld = (holder >= 0);
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit s, input bit en, input logic [N-1:0] rq, input bit dn);
        @(negedge clk);
        sclr       = s;
        ifc.clken  = en;
        ifc.i_req  = rq;
        ifc.i_done = dn;
        model_step(s, en, rq, dn);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (ifc.o_gnt !== e.gnt || ifc.o_gnt_idx !== e.idx ||
                ifc.o_gnt_valid !== e.vld || ifc.o_timeout !== e.tmo) begin
                miscompares++;
                $display("FAIL outputs @%0t: got gnt=%b idx=%0d vld=%b tmo=%b, want gnt=%b idx=%0d vld=%b tmo=%b",
                         $time, ifc.o_gnt, ifc.o_gnt_idx, ifc.o_gnt_valid, ifc.o_timeout,
                         e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    end

    initial begin
        ifc.clken  = 1'b1;
        ifc.i_req  = '0;
        ifc.i_done = 1'b0;

        // Reset with all requests pending, then first grant to requester 0.
        cyc(1, 1, 4'b1111, 0);
        cyc(1, 1, 4'b1111, 0);
        cyc(0, 1, 4'b1111, 0);

        // Fairness: release every grant immediately, rotation 0,1,2,3,0.
        for (int i = 0; i < 10; i++) cyc(0, 1, 4'b1111, holder >= 0);

        // Drive pointer to 3 via a grant to idx 2, then skip/wrap with 0011.
        cyc(1, 1, 4'b0000, 0);
        cyc(0, 1, 4'b0100, 0);
        cyc(0, 1, 4'b0100, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'b0011, holder >= 0);

        // Release by request drop on idx 1, then search from idx 2.
        cyc(1, 1, 4'b0000, 0);
        cyc(0, 1, 4'b0010, 0);
        cyc(0, 1, 4'b0010, 0);
        cyc(0, 1, 4'b0000, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'b0111, 0);

        // Forced release after the hold limit, then regrant after the bubble.
        cyc(1, 1, 4'b0000, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 4'b0100, 0);

        // Clock enable stall mid-grant, then clear while disabled.
        cyc(1, 1, 4'b0000, 0);
        cyc(0, 1, 4'b0010, 0);
        cyc(0, 1, 4'b0010, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0010, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'b0010, 0);
        cyc(0, 1, 4'b1000, 0);
        cyc(1, 0, 4'b1000, 0);
        cyc(0, 1, 4'b0000, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rq;
            rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0 && holder >= 0) rq[holder] = 1'b1;
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, rq, $urandom_range(0, 4) == 0);
        end

        // Drain with a bound so a stuck monitor still reaches the summary.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
